oam_dma_ctrl: RTL and testbench
===============================

OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

Interface
REQ-001 Clocking/reset SHALL be one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  system clock; one clk edge = one CPU cycle.
REQ-003 b_rst  in  1  asynchronous active-low reset.
REQ-004 cpu_addr_out  in  16  CPU address.
REQ-005 cpu_data_out  in  8  CPU write data.
REQ-006 ren  in  1  CPU read strobe.
REQ-007 wen  in  1  CPU write strobe.
REQ-008 rdy  out  1  CPU ready; 0 halts CPU.
REQ-009 cpu_data_in  out  8  read data returned to CPU (bus_data_in passthrough).
REQ-010 bus_addr  out  16  shared memory-bus address.
REQ-011 bus_data_out  out  8  shared memory-bus write data.
REQ-012 bus_ren  out  1  shared memory-bus read strobe.
REQ-013 bus_wen  out  1  shared memory-bus write strobe.
REQ-014 bus_data_in  in  8  memory read data, valid combinationally in the same cycle as bus_ren.
REQ-015 dma_active  out  1  high while the DMA owns the bus or holds rdy low.

Function
REQ-016 Trigger SHALL be a CPU cycle with wen=1 and cpu_addr_out=16'h4014 while in IDLE; page register P SHALL capture cpu_data_out.
REQ-017 The trigger write SHALL itself pass through to the bus unchanged.
REQ-018 FSM states SHALL be IDLE, HALT, ALIGN, READ, WRITE.
REQ-019 IDLE -> HALT on trigger; rdy SHALL go 0 in the first HALT cycle.
REQ-020 In HALT, while wen=1 (CPU write, which cannot be halted), the FSM SHALL stay in HALT and the CPU SHALL own the bus.
REQ-021 A parity flop SHALL toggle every clk and reset to 0.
REQ-022 HALT with wen=0 SHALL go to READ if parity=1, else to ALIGN; ALIGN -> READ unconditionally, so that every READ occurs at parity=0.
REQ-023 READ SHALL drive bus_addr={P,idx} with bus_ren=1; data latch D SHALL capture bus_data_in at the READ clock edge.
REQ-024 WRITE SHALL drive bus_addr=16'h2004, bus_data_out=D, bus_wen=1.
REQ-025 idx SHALL be 8 bits, reset to 0 on trigger, and increment after each WRITE.
REQ-026 WRITE -> READ while idx!=8'hFF; WRITE with idx=8'hFF -> IDLE, and idx SHALL wrap to 0.
REQ-027 rdy SHALL be 0 and dma_active 1 in HALT, ALIGN, READ and WRITE; rdy SHALL return to 1 in the cycle after the last WRITE.
REQ-028 Outside READ/WRITE, the bus outputs SHALL mirror the CPU signals combinationally; in READ/WRITE the CPU's ren/wen SHALL be blocked.
REQ-029 A $4014 write while the FSM is not IDLE SHALL be passed to the bus but SHALL NOT retrigger or change P.
REQ-030 Total rdy-low time with no HALT extension SHALL be 513 cycles (entry parity=1) or 514 cycles (entry parity=0).
REQ-031 P=8'hFF SHALL read addresses 16'hFF00 through 16'hFFFF with no wrap into the next page.

Reset
REQ-032 During reset the block SHALL be in IDLE, with rdy=1, dma_active=0, parity=0, idx=0, P=0 and D=0.
REQ-033 Reset asserted mid-transfer SHALL abort immediately to the REQ-032 values, with no further bus strobes.

Structure
REQ-034 Package nes_bus_pkg SHALL hold OAMDMA_ADDR=16'h4014, OAMDATA_ADDR=16'h2004 and the dma_state_t enum.
REQ-035 The block SHALL be a single module with no sub-module; the FSM, counters and bus mux SHALL all be local.

Verification
REQ-036 Trigger with P=8'h02 at parity=0, RAM $0200+i=i -> rdy low for 514 cycles; 256 writes to $2004 carrying 0x00..0xFF in order.
REQ-037 Same stimulus with the trigger at parity=1 -> rdy low for exactly 513 cycles; first READ addr=16'h0200.
REQ-038 CPU holds wen=1 for 2 cycles after the trigger -> HALT extended by 2 cycles; those CPU writes appear on the bus unmodified.
REQ-039 P=8'hFF -> last READ addr=16'hFFFF, FSM returns to IDLE, idx=0.
REQ-040 b_rst pulsed low after the 100th WRITE -> rdy=1 and bus strobes idle immediately; a new trigger afterwards restarts at idx=0.
REQ-041 A second $4014 write forced during an active DMA -> P unchanged and total cycle count unchanged.

Source files
------------

// File: rtl/nes_bus_pkg.sv
// Shared NES bus constants and the OAM DMA state encoding.
package nes_bus_pkg;

    localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
    localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_ALIGN,
        ST_READ,
        ST_WRITE
    } dma_state_t;

endpackage

// File: rtl/oam_dma_ctrl_if.sv
// CPU-side and memory-bus-side signals of the OAM DMA controller.
interface oam_dma_ctrl_if;

    logic [15:0] cpu_addr_out;
    logic [7:0]  cpu_data_out;
    logic        ren;
    logic        wen;
    logic        rdy;
    logic [7:0]  cpu_data_in;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data_out;
    logic        bus_ren;
    logic        bus_wen;
    logic [7:0]  bus_data_in;
    logic        dma_active;

    // The DMA controller sits between the CPU and the shared memory bus.
    modport master (
        input  cpu_addr_out, cpu_data_out, ren, wen, bus_data_in,
        output rdy, cpu_data_in, bus_addr, bus_data_out, bus_ren, bus_wen, dma_active
    );

    modport slave (
        output cpu_addr_out, cpu_data_out, ren, wen, bus_data_in,
        input  rdy, cpu_data_in, bus_addr, bus_data_out, bus_ren, bus_wen, dma_active
    );

endinterface

// File: rtl/oam_dma_ctrl.sv
// OAM DMA: on a $4014 write, halts the CPU and copies page P ($PP00-$PPFF) to $2004.
module oam_dma_ctrl
    import nes_bus_pkg::*;
(
    input  logic           clk,
    input  logic           b_rst,
    oam_dma_ctrl_if.master bus
);

    dma_state_t  state_q;
    logic        parity_q;
    logic [7:0]  idx_q;
    logic [7:0]  idx_d;
    logic [7:0]  page_q;
    logic [7:0]  data_q;
    logic        rdy_q;
    logic        active_q;
    logic        trigger;

    assign trigger = bus.wen && (bus.cpu_addr_out == OAMDMA_ADDR);
    assign idx_d   = idx_q + 8'd1;

    always_ff @(posedge clk or negedge b_rst) begin
        if (!b_rst) begin
            state_q  <= ST_IDLE;
            parity_q <= 1'b0;
            idx_q    <= 8'h00;
            page_q   <= 8'h00;
            data_q   <= 8'h00;
            rdy_q    <= 1'b1;
            active_q <= 1'b0;
        end else begin
            parity_q <= ~parity_q;
            case (state_q)
                ST_IDLE: begin
                    if (trigger) begin
                        state_q  <= ST_HALT;
                        page_q   <= bus.cpu_data_out;
                        idx_q    <= 8'h00;
                        rdy_q    <= 1'b0;
                        active_q <= 1'b1;
                    end
                end
                ST_HALT: begin
                    // A CPU write cannot be stalled, so hold here until it ends.
                    // Leaving at parity=1 lands READ on parity=0.
                    if (!bus.wen) begin
                        state_q <= parity_q ? ST_READ : ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    state_q <= ST_READ;
                end
                ST_READ: begin
                    data_q  <= bus.bus_data_in;
                    state_q <= ST_WRITE;
                end
                ST_WRITE: begin
                    idx_q <= idx_d;
                    if (idx_q == 8'hFF) begin
                        state_q  <= ST_IDLE;
                        rdy_q    <= 1'b1;
                        active_q <= 1'b0;
                    end else begin
                        state_q <= ST_READ;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    rdy_q    <= 1'b1;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    // Bus mux: the CPU owns the bus except during the DMA's own READ/WRITE cycles.
    always_comb begin
        bus.bus_addr     = bus.cpu_addr_out;
        bus.bus_data_out = bus.cpu_data_out;
        bus.bus_ren      = bus.ren;
        bus.bus_wen      = bus.wen;
        case (state_q)
            ST_READ: begin
                bus.bus_addr = {page_q, idx_q};
                bus.bus_ren  = 1'b1;
                bus.bus_wen  = 1'b0;
            end
            ST_WRITE: begin
                bus.bus_addr     = OAMDATA_ADDR;
                bus.bus_data_out = data_q;
                bus.bus_ren      = 1'b0;
                bus.bus_wen      = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.cpu_data_in = bus.bus_data_in;
    assign bus.rdy         = rdy_q;
    assign bus.dma_active  = active_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Randomized bench for oam_dma_ctrl against a transfer-level reference model.
module tb_oam_dma_ctrl;
    import nes_bus_pkg::*;

    logic clk = 1'b0;
    logic b_rst;

    oam_dma_ctrl_if bus ();

    oam_dma_ctrl dut (
        .clk   (clk),
        .b_rst (b_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:65535];
    assign bus.bus_data_in = ram[bus.bus_addr];

    // Edges since reset release; parity during a cycle is its low bit.
    int unsigned edge_cnt;
    always @(posedge clk or negedge b_rst) begin
        if (!b_rst) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    int total = 0;
    int bad   = 0;
    logic [15:0] rd_q[$];
    logic [7:0]  wr_q[$];
    int low_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.wen          = 1'b0;
        bus.ren          = 1'b0;
        bus.cpu_addr_out = 16'h0000;
        bus.cpu_data_out = 8'h00;
    endtask

    // One DMA: trigger with page p so the first HALT cycle has parity par,
    // CPU write extension of ext cycles, optional forced $4014 at loop cycle force_at,
    // optional reset once abort_at writes have been seen.
    task automatic run_dma(input logic [7:0] p, input int ext, input bit par,
                           input int force_at, input int abort_at, input string name);
        int   exp_low;
        bit   last_par;
        bit   done;
        bit   aborted;
        logic [7:0] wdata;
        logic [15:0] waddr;
        done    = 1'b0;
        aborted = 1'b0;
        rd_q.delete();
        wr_q.delete();
        low_cnt = 0;
        @(negedge clk);
        if (((edge_cnt + 1) % 2) != par) @(negedge clk);
        bus.wen          = 1'b1;
        bus.cpu_addr_out = OAMDMA_ADDR;
        bus.cpu_data_out = p;
        #1;
        chk({name, ":trig_pass"}, 32'({bus.bus_wen, bus.bus_addr, bus.bus_data_out}),
            32'({1'b1, OAMDMA_ADDR, p}));
        chk({name, ":rdy_idle"}, 32'(bus.rdy), 32'd1);
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            if (abort_at > 0 && wr_q.size() == abort_at) begin
                idle_inputs();
                b_rst = 1'b0;
                #1;
                chk({name, ":abort_rdy"}, 32'(bus.rdy), 32'd1);
                chk({name, ":abort_act"}, 32'(bus.dma_active), 32'd0);
                chk({name, ":abort_strobes"}, 32'({bus.bus_ren, bus.bus_wen}), 32'd0);
                @(negedge clk);
                chk({name, ":abort_hold"}, 32'({bus.bus_ren, bus.bus_wen, bus.rdy}), 32'd1);
                @(negedge clk);
                b_rst   = 1'b1;
                aborted = 1'b1;
                break;
            end
            if (k < ext) begin
                waddr = 16'(16'h0300 + k);
                wdata = 8'($urandom);
                bus.wen          = 1'b1;
                bus.cpu_addr_out = waddr;
                bus.cpu_data_out = wdata;
            end else if (k == force_at) begin
                bus.wen          = 1'b1;
                bus.cpu_addr_out = OAMDMA_ADDR;
                bus.cpu_data_out = ~p;
            end else begin
                idle_inputs();
            end
            #1;
            if (k < ext) begin
                chk({name, ":halt_cpu_wr"}, 32'({bus.bus_wen, bus.bus_ren, bus.bus_addr, bus.bus_data_out}),
                    32'({1'b1, 1'b0, waddr, wdata}));
                chk({name, ":halt_rdy"}, 32'(bus.rdy), 32'd0);
            end
            if (bus.rdy) begin
                done = 1'b1;
                break;
            end
            low_cnt++;
            if (bus.bus_ren && !bus.ren) rd_q.push_back(bus.bus_addr);
            if (bus.bus_wen && bus.bus_addr == OAMDATA_ADDR) wr_q.push_back(bus.bus_data_out);
        end
        idle_inputs();
        if (abort_at > 0) begin
            chk({name, ":aborted"}, 32'(aborted), 32'd1);
            $display("dma %s p=%h aborted after %0d writes", name, p, wr_q.size());
            return;
        end
        chk({name, ":done"}, 32'(done), 32'd1);
        // Reference: HALT lasts ext+1 cycles; one ALIGN if it ends on parity 0; then 256 READ/WRITE pairs.
        last_par = par ^ ext[0];
        exp_low  = ext + 1 + (last_par ? 0 : 1) + 512;
        chk({name, ":low_cycles"}, 32'(low_cnt), 32'(exp_low));
        chk({name, ":n_reads"}, 32'(rd_q.size()), 32'd256);
        chk({name, ":n_writes"}, 32'(wr_q.size()), 32'd256);
        for (int i = 0; i < 256; i++) begin
            if (i < rd_q.size()) chk({name, ":rd_addr"}, 32'(rd_q[i]), 32'({p, 8'(i)}));
            if (i < wr_q.size()) chk({name, ":wr_data"}, 32'(wr_q[i]), 32'(ram[{p, 8'(i)}]));
        end
        #1;
        chk({name, ":end_act"}, 32'(bus.dma_active), 32'd0);
        chk({name, ":end_strobes"}, 32'({bus.bus_ren, bus.bus_wen}), 32'd0);
        $display("dma %s p=%h ext=%0d par=%0d low=%0d exp_low=%0d reads=%0d writes=%0d",
                 name, p, ext, par, low_cnt, exp_low, rd_q.size(), wr_q.size());
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) ram[a] = 8'($urandom);
        for (int i = 0; i < 256; i++) ram[16'h0200 + i] = 8'(i);

        idle_inputs();
        b_rst = 1'b0;
        #12;
        bus.ren          = 1'b1;
        bus.cpu_addr_out = 16'h1234;
        #1;
        chk("reset:rdy", 32'(bus.rdy), 32'd1);
        chk("reset:act", 32'(bus.dma_active), 32'd0);
        chk("reset:mirror", 32'({bus.bus_ren, bus.bus_wen, bus.bus_addr}), 32'({1'b1, 1'b0, 16'h1234}));
        chk("reset:rdata", 32'(bus.cpu_data_in), 32'(ram[16'h1234]));
        idle_inputs();
        @(negedge clk);
        b_rst = 1'b1;
        repeat (3) @(negedge clk);

        run_dma(8'h02, 0, 1'b0, -1, 0, "par0");
        run_dma(8'h02, 0, 1'b1, -1, 0, "par1");
        run_dma(8'h02, 2, 1'b0, -1, 0, "ext2");
        run_dma(8'hFF, 0, 1'($urandom), -1, 0, "pageff");
        run_dma(8'h02, 0, 1'b0, -1, 100, "abort");
        run_dma(8'h05, 0, 1'b1, -1, 0, "restart");
        run_dma(8'h03, 1, 1'b0, 60, 0, "retrig");
        for (int t = 0; t < 4; t++) begin
            run_dma(8'($urandom), int'($urandom_range(0, 3)), 1'($urandom),
                    (t % 2 == 0) ? int'($urandom_range(10, 400)) : -1, 0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
